// File: rtl/dmem_bridge_pkg.sv
// Shared encodings and lane helpers for the M-stage data-memory bridge.
// Access sizes, FSM states and store strobe/lane-data builders.
package dmem_bridge_pkg;

   localparam logic [1:0] SizeB = 2'b00;
   localparam logic [1:0] SizeH = 2'b01;
   localparam logic [1:0] SizeW = 2'b10;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2,
      StDone = 2'd3
   } state_e;

   // Low address bits after forcing natural alignment for the access size.
   function automatic logic [1:0] alignLow(input logic [1:0] size, input logic [1:0] low);
      case (size)
         SizeB:   alignLow = low;
         SizeH:   alignLow = {low[1], 1'b0};
         default: alignLow = 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] strobes(input logic [1:0] size, input logic [1:0] low);
      case (size)
         SizeB:   strobes = 4'b0001 << low;
         SizeH:   strobes = 4'b0011 << {low[1], 1'b0};
         default: strobes = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SizeB:   laneData = {4{wdata[7:0]}};
         SizeH:   laneData = {2{wdata[15:0]}};
         default: laneData = wdata;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bridge_load_ext.sv
// Load lane select and sign/zero extension for the bridge capture path.
module dmem_bridge_load_ext
   import dmem_bridge_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        signExt,
   output logic [31:0] result
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   always_comb begin
      case (lane)
         2'd0:    byteSel = rdata[7:0];
         2'd1:    byteSel = rdata[15:8];
         2'd2:    byteSel = rdata[23:16];
         default: byteSel = rdata[31:24];
      endcase
      halfSel = lane[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SizeB:   result = {{24{signExt & byteSel[7]}}, byteSel};
         SizeH:   result = {{16{signExt & halfSel[15]}}, halfSel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: request/grant/response bus transaction with pipeline stall.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned accesses instead of forcing alignment.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          memreadM,
   input  logic          memwriteM,
   input  logic [1:0]    sizeM,
   input  logic          signedM,
   input  logic [31:0]   addrM,
   input  logic [31:0]   wdataM,
   input  logic          holdM,
   output logic          stallM,
   output logic [31:0]   rdataM,
   output logic          adelM,
   output logic          adesM,
   output logic          buserrM,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [3:0]    bus_wstrb,
   output logic [31:0]   bus_wdata,
   input  logic          bus_gnt,
   input  logic          bus_rvalid,
   input  logic [31:0]   bus_rdata
);

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e        stateQ, stateD;
   logic [1:0]    addrLowQ, sizeQ;
   logic          signedQ;
   logic [7:0]    cntQ;
   logic          busReqQ, busWeQ, buserrQ;
   logic [AW-1:0] busAddrQ;
   logic [3:0]    busWstrbQ;
   logic [31:0]   busWdataQ, rdataQ, extData;
   logic          memReq, misaligned;
   logic [1:0]    alignedLow;

   assign memReq     = memreadM | memwriteM;
   assign alignedLow = alignLow(sizeM, addrM[1:0]);

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = ((sizeM == SizeH) & addrM[0]) |
                       ((sizeM == SizeW) & (addrM[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   dmem_bridge_load_ext loadExt (
      .rdata   (bus_rdata),
      .lane    (addrLowQ),
      .size    (sizeQ),
      .signExt (signedQ),
      .result  (extData)
   );

   always_ff @(posedge clk) begin
      if (!rst) stateQ <= StIdle;
      else      stateQ <= stateD;
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         StIdle:  if (memReq & ~misaligned) stateD = StReq;
         StReq:   if (bus_gnt) stateD = StWait;
         StWait:  if (bus_rvalid || (cntQ == CntLast)) stateD = StDone;
         StDone:  if (!holdM) stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_comb begin
      stallM = (stateQ != StDone) & memReq & ~misaligned;
      adelM  = (stateQ == StIdle) & memreadM & misaligned;
      adesM  = (stateQ == StIdle) & memwriteM & misaligned;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         addrLowQ  <= 2'b00;
         sizeQ     <= 2'b00;
         signedQ   <= 1'b0;
         cntQ      <= 8'd0;
         busReqQ   <= 1'b0;
         busWeQ    <= 1'b0;
         busAddrQ  <= '0;
         busWstrbQ <= 4'b0000;
         busWdataQ <= 32'd0;
         rdataQ    <= 32'd0;
         buserrQ   <= 1'b0;
      end else begin
         case (stateQ)
            StIdle: begin
               if (memReq & ~misaligned) begin
                  busReqQ   <= 1'b1;
                  busWeQ    <= memwriteM;
                  busAddrQ  <= {addrM[AW-1:2], 2'b00};
                  busWstrbQ <= strobes(sizeM, alignedLow);
                  busWdataQ <= laneData(sizeM, wdataM);
                  addrLowQ  <= alignedLow;
                  sizeQ     <= sizeM;
                  signedQ   <= signedM;
               end
            end
            StReq: begin
               if (bus_gnt) begin
                  busReqQ <= 1'b0;
                  cntQ    <= 8'd0;
               end
            end
            StWait: begin
               if (bus_rvalid) begin
                  rdataQ  <= extData;
                  buserrQ <= 1'b0;
               end else if (cntQ == CntLast) begin
                  rdataQ  <= 32'd0;
                  buserrQ <= 1'b1;
               end else begin
                  cntQ <= cntQ + 8'd1;
               end
            end
            StDone: begin
               // Error is reported only for the instruction that owns this DONE.
               if (!holdM) buserrQ <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign rdataM    = rdataQ;
   assign buserrM   = buserrQ;
   assign bus_req   = busReqQ;
   assign bus_we    = busWeQ;
   assign bus_addr  = busAddrQ;
   assign bus_wstrb = busWstrbQ;
   assign bus_wdata = busWdataQ;

endmodule
